ibex_mem_arbiter: RTL
=====================

IBEX_MEM_ARBITER -- requirements
Module: ibex_mem_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2, meaning the maximum number of granted requests awaiting rvalid (range 1..8).
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port rst_ni, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have instruction host ports: instr_req_i in 1; instr_gnt_o out 1; instr_rvalid_o out 1; instr_addr_i in 32; instr_rdata_o out 32; instr_err_o out 1.
REQ-005 SHALL have data host ports: data_req_i in 1; data_gnt_o out 1; data_rvalid_o out 1; data_we_i in 1; data_be_i in 4; data_addr_i in 32; data_wdata_i in 32; data_rdata_o out 32; data_err_o out 1.
REQ-006 SHALL have device ports: mem_req_o out 1; mem_gnt_i in 1; mem_rvalid_i in 1; mem_we_o out 1; mem_be_o out 4; mem_addr_o out 32; mem_wdata_o out 32; mem_rdata_i in 32; mem_err_i in 1.
REQ-007 SHALL have port spurious_rvalid_o, output, 1, one-cycle pulse on an rvalid with no outstanding request.

Function
REQ-008 SHALL assert mem_req_o when at least one host request is pending and the outstanding count is below MaxOutstanding; no mem_gnt_i/mem_rvalid_i to mem_req_o combinational path.
REQ-009 SHALL forward the selected host's address/we/be/wdata to the device; an instruction request SHALL drive we=0, be=4'hF, wdata=0.
REQ-010 SHALL implement states IDLE and LOCKED: IDLE->LOCKED when mem_req_o=1 and mem_gnt_i=0; LOCKED->IDLE on mem_gnt_i=1.
REQ-011 SHALL, in LOCKED, keep the owner registered at lock time selected regardless of the other host's request.
REQ-012 SHALL assert exactly the selected host's gnt, combinationally equal to mem_gnt_i and mem_req_o; the other host's gnt SHALL be 0.
REQ-013 SHALL on every device grant push the owner ID into an in-order response FIFO of depth MaxOutstanding.
REQ-014 SHALL on mem_rvalid_i with a non-empty FIFO pop the head and assert rvalid only on the head owner's port in the same cycle (zero latency).
REQ-015 SHALL broadcast mem_rdata_i and mem_err_i to both hosts' rdata/err outputs unregistered.
REQ-016 SHALL on mem_rvalid_i with an empty FIFO assert no host rvalid, leave the count at 0, and pulse spurious_rvalid_o.
REQ-017 SHALL treat grant and rvalid in the same cycle as simultaneous push and pop, count unchanged.
REQ-018 SHALL, when the count equals MaxOutstanding, deassert mem_req_o even if an rvalid arrives that cycle; request resumes next cycle.
REQ-019 SHALL never wrap the count: push at full and pop at empty cannot occur.

Reset
REQ-020 SHALL on rst_ni=0 asynchronously clear: state to IDLE, FIFO and count to empty, round-robin pointer to "instruction last served".
REQ-021 SHALL hold all outputs at 0 during reset; outstanding transactions are dropped and their later rvalids are reported as spurious.

Configuration
REQ-022 SHALL use macro IBEX_MEM_ARB_ROUND_ROBIN_EN: defined -> on contention grant the host not served last, pointer updated on each device grant; undefined -> data host has fixed priority and the pointer is not built.

Structure
REQ-023 SHALL declare in ibex_pkg: typedef enum logic {ARB_INSTR=1'b0, ARB_DATA=1'b1} mem_arb_owner_e.
REQ-024 SHALL implement the owner FIFO as sub-module ibex_mem_arb_fifo (parameter Depth, push/pop/full/empty/head).

Verification
REQ-025 SHALL cover: only instr_req_i=1 addr 0x100, mem_gnt_i=1 -> instr_gnt_o=1, mem_addr_o=0x100, mem_we_o=0, mem_be_o=4'hF; rvalid next cycle with rdata 0xDEADBEEF -> instr_rvalid_o=1, data_rvalid_o=0.
REQ-026 SHALL cover: both request, mem_gnt_i=0 for 3 cycles then 1 -> owner and mem_addr_o stable for 4 cycles, one grant only.
REQ-027 SHALL cover: both request continuously, immediate grants, macro defined -> grants alternate data, instr, data, instr; macro undefined -> data every cycle.
REQ-028 SHALL cover: MaxOutstanding=2, two grants with no rvalid -> mem_req_o=0 on third cycle; rvalid -> mem_req_o=1 the next cycle.
REQ-029 SHALL cover: mem_rvalid_i=1 after reset with nothing outstanding -> spurious_rvalid_o=1 for one cycle, no host rvalid.
REQ-030 SHALL cover: rst_ni low with 2 outstanding, then 2 rvalids after release -> both flagged spurious, count stays 0.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared types for the Ibex memory arbiter: host identifiers, arbiter
// states and small helpers used by the arbiter and its response FIFO.
package ibex_pkg;

  typedef enum logic {
    ARB_INSTR = 1'b0,
    ARB_DATA  = 1'b1
  } mem_arb_owner_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } mem_arb_state_e;

  // Instruction fetches are always full-word reads.
  localparam logic [3:0] ARB_INSTR_BE = 4'hF;

  // The host that is not the given one.
  function automatic mem_arb_owner_e arb_other(input mem_arb_owner_e owner);
    return (owner == ARB_INSTR) ? ARB_DATA : ARB_INSTR;
  endfunction

endpackage

// File: rtl/ibex_mem_arb_fifo.sv
// In-order FIFO of host IDs for granted requests still waiting for rvalid.
// The head names the host that owns the next response from the device.
module ibex_mem_arb_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_i,
  input  mem_arb_owner_e push_owner_i,
  input  logic           pop_i,
  output logic           full_o,
  output logic           empty_o,
  output mem_arb_owner_e head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  mem_arb_owner_e  slots_q [Depth];
  logic [PtrW-1:0] wptr_q;
  logic [PtrW-1:0] rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (cnt_q == DepthCnt);
  assign empty_o = (cnt_q == '0);
  assign head_o  = slots_q[rptr_q];

  // Guards keep the count from ever wrapping even if a caller misbehaves.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Slot storage carries only data, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      slots_q[wptr_q] <= push_owner_i;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// Arbiter sharing one memory device between the Ibex instruction and data
// hosts. A request that is not granted immediately locks the arbiter onto
// its host until the device grants. Responses return in order and are
// steered by an owner FIFO.
// Build option: define IBEX_MEM_ARB_ROUND_ROBIN_EN to alternate between the
// hosts on contention; otherwise the data host always wins.
module ibex_mem_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,

  output logic        spurious_rvalid_o
);

  mem_arb_state_e state_q;
  mem_arb_owner_e owner_q;
  mem_arb_owner_e sel;
  mem_arb_owner_e head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           req_int;
  logic           dev_gnt;
  logic           rsp_pop;

`ifdef IBEX_MEM_ARB_ROUND_ROBIN_EN
  mem_arb_owner_e last_q;

  // Remember which host the device granted most recently.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= ARB_INSTR;
    end else if (dev_gnt) begin
      last_q <= sel;
    end
  end
`endif

  // The request depends only on host requests and the registered FIFO level,
  // never on this cycle's grant or rvalid.
  assign req_int = (instr_req_i | data_req_i) & ~fifo_full;
  assign dev_gnt = req_int & mem_gnt_i;
  assign rsp_pop = mem_rvalid_i & ~fifo_empty;

  // Owner selection: a locked owner wins outright, otherwise arbitrate.
  always_comb begin
    sel = ARB_INSTR;
    if (state_q == ARB_LOCKED) begin
      sel = owner_q;
    end else if (instr_req_i && data_req_i) begin
`ifdef IBEX_MEM_ARB_ROUND_ROBIN_EN
      sel = arb_other(last_q);
`else
      sel = ARB_DATA;
`endif
    end else if (data_req_i) begin
      sel = ARB_DATA;
    end
  end

  // Lock FSM: hold the selected host until the device finally grants it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      owner_q <= ARB_INSTR;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (req_int && !mem_gnt_i) begin
            state_q <= ARB_LOCKED;
            owner_q <= sel;
          end
        end
        ARB_LOCKED: begin
          if (mem_gnt_i) begin
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  ibex_mem_arb_fifo #(
    .Depth(MaxOutstanding)
  ) u_owner_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (dev_gnt),
    .push_owner_i(sel),
    .pop_i       (rsp_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  // Device-side request and forwarded attributes; all outputs read 0 in reset.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (rst_ni) begin
      mem_req_o = req_int;
      if (sel == ARB_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = ARB_INSTR_BE;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  // Host-side grants, response steering and broadcast read data.
  always_comb begin
    instr_gnt_o       = 1'b0;
    data_gnt_o        = 1'b0;
    instr_rvalid_o    = 1'b0;
    data_rvalid_o     = 1'b0;
    instr_rdata_o     = 32'h0;
    data_rdata_o      = 32'h0;
    instr_err_o       = 1'b0;
    data_err_o        = 1'b0;
    spurious_rvalid_o = 1'b0;
    if (rst_ni) begin
      instr_gnt_o       = dev_gnt & (sel == ARB_INSTR);
      data_gnt_o        = dev_gnt & (sel == ARB_DATA);
      instr_rvalid_o    = rsp_pop & (head == ARB_INSTR);
      data_rvalid_o     = rsp_pop & (head == ARB_DATA);
      instr_rdata_o     = mem_rdata_i;
      data_rdata_o      = mem_rdata_i;
      instr_err_o       = mem_err_i;
      data_err_o        = mem_err_i;
      spurious_rvalid_o = mem_rvalid_i & fifo_empty;
    end
  end

endmodule
